// File: rtl/sdram_timing_monitor.sv
// Passive SDRAM command-bus checker: tracks the init sequence, open banks and
// tRCD/tRP/tRFC/refresh-interval windows, and reports violations as sticky flags.
module sdram_timing_monitor #(
  parameter int SDRAM_BANKS  = 4,
  parameter int SDRAM_BANK_W = (SDRAM_BANKS > 1) ? $clog2(SDRAM_BANKS) : 1,
  parameter int SDRAM_ROW_W  = 13,
  parameter int T_RCD        = 3,
  parameter int T_RP         = 3,
  parameter int T_RFC        = 7,
  parameter int REFRESH_MAX  = 6500,
  parameter int CNT_W        = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sdram_cke_i,
  input  logic                    sdram_cs_i,
  input  logic                    sdram_ras_i,
  input  logic                    sdram_cas_i,
  input  logic                    sdram_we_i,
  input  logic [SDRAM_BANK_W-1:0] sdram_ba_i,
  input  logic [SDRAM_ROW_W-1:0]  sdram_addr_i,
  input  logic                    clear_i,
  output logic [7:0]              err_o,
  output logic                    err_pulse_o,
  output logic [CNT_W-1:0]        err_count_o,
  output logic                    init_done_o,
  output logic [SDRAM_BANKS-1:0]  bank_open_o
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MODE = 4'b0000;

  // A window of N cycles loads N-1; the follow-up is legal once the timer reads 0.
  localparam int RCD_W = (T_RCD > 1) ? $clog2(T_RCD) : 1;
  localparam int RP_W  = (T_RP > 1) ? $clog2(T_RP) : 1;
  localparam int RFC_W = (T_RFC > 1) ? $clog2(T_RFC) : 1;
  localparam int RI_W  = $clog2(REFRESH_MAX + 2);

  localparam logic [RCD_W-1:0] RCD_LD  = (T_RCD > 1) ? RCD_W'(T_RCD - 1) : '0;
  localparam logic [RP_W-1:0]  RP_LD   = (T_RP > 1) ? RP_W'(T_RP - 1) : '0;
  localparam logic [RFC_W-1:0] RFC_LD  = (T_RFC > 1) ? RFC_W'(T_RFC - 1) : '0;
  localparam logic [RI_W-1:0]  RI_LAST = RI_W'(REFRESH_MAX);
  localparam logic [RI_W-1:0]  RI_LATE = RI_W'(REFRESH_MAX + 1);

  typedef enum logic [2:0] {
    ST_INIT_PRE,
    ST_INIT_REF0,
    ST_INIT_REF1,
    ST_INIT_MODE,
    ST_RUN
  } state_e;

  state_e state_q, state_d;

  logic [3:0] cmd;
  logic       cmd_live;
  logic       is_act, is_rw, is_pre, is_ref, is_mode;
  logic       run;
  logic       init_err;
  logic       unused_addr;

  assign cmd      = {sdram_cs_i, sdram_ras_i, sdram_cas_i, sdram_we_i};
  assign cmd_live = sdram_cke_i & ~sdram_cs_i & (cmd != CMD_NOP);
  assign is_act   = cmd_live & (cmd == CMD_ACT);
  assign is_rw    = cmd_live & ((cmd == CMD_RD) | (cmd == CMD_WR));
  assign is_pre   = cmd_live & (cmd == CMD_PRE);
  assign is_ref   = cmd_live & (cmd == CMD_REF);
  assign is_mode  = cmd_live & (cmd == CMD_MODE);
  assign run      = (state_q == ST_RUN);

  // Only bit 10 (precharge-all) matters to the monitor.
  assign unused_addr = ^sdram_addr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT_PRE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    init_err = 1'b0;
    case (state_q)
      ST_INIT_PRE: begin
        if (is_pre) state_d = ST_INIT_REF0;
        else        init_err = cmd_live;
      end
      ST_INIT_REF0: begin
        if (is_ref) state_d = ST_INIT_REF1;
        else        init_err = cmd_live;
      end
      ST_INIT_REF1: begin
        if (is_ref) state_d = ST_INIT_MODE;
        else        init_err = cmd_live;
      end
      ST_INIT_MODE: begin
        if (is_mode) state_d = ST_RUN;
        else         init_err = cmd_live;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT_PRE;
      end
    endcase
  end

  logic [SDRAM_BANKS-1:0] bank_sel, act_hit, pre_hit, rcd_busy, rp_busy;
  logic [SDRAM_BANKS-1:0] open_q, open_d;
  logic [RCD_W-1:0]       rcd_q [SDRAM_BANKS];
  logic [RCD_W-1:0]       rcd_d [SDRAM_BANKS];
  logic [RP_W-1:0]        rp_q  [SDRAM_BANKS];
  logic [RP_W-1:0]        rp_d  [SDRAM_BANKS];

  for (genvar gi = 0; gi < SDRAM_BANKS; gi++) begin : g_bank
    assign bank_sel[gi] = (sdram_ba_i == SDRAM_BANK_W'(gi));
    assign act_hit[gi]  = run & is_act & bank_sel[gi];
    assign pre_hit[gi]  = run & is_pre & (bank_sel[gi] | sdram_addr_i[10]);
    assign rcd_busy[gi] = (rcd_q[gi] != '0);
    assign rp_busy[gi]  = (rp_q[gi] != '0);
    assign open_d[gi]   = act_hit[gi] | (open_q[gi] & ~pre_hit[gi]);
    assign rcd_d[gi]    = act_hit[gi]  ? RCD_LD :
                          rcd_busy[gi] ? rcd_q[gi] - RCD_W'(1) : rcd_q[gi];
    assign rp_d[gi]     = pre_hit[gi]  ? RP_LD :
                          rp_busy[gi]  ? rp_q[gi] - RP_W'(1) : rp_q[gi];
  end

  logic             open_sel, rcd_sel, rp_sel;
  logic [RFC_W-1:0] rfc_q, rfc_d;
  logic             rfc_busy;
  logic [RI_W-1:0]  ri_q, ri_d;

  assign open_sel = |(open_q & bank_sel);
  assign rcd_sel  = |(rcd_busy & bank_sel);
  assign rp_sel   = |(rp_busy & bank_sel);
  assign rfc_busy = (rfc_q != '0);
  assign rfc_d    = is_ref   ? RFC_LD :
                    rfc_busy ? rfc_q - RFC_W'(1) : rfc_q;

  // Interval counter parks at REFRESH_MAX+1 so a late interval flags only once.
  always_comb begin
    ri_d = ri_q;
    if (state_q == ST_INIT_MODE && is_mode) begin
      ri_d = '0;
    end else if (run && is_ref) begin
      ri_d = '0;
    end else if (run && ri_q != RI_LATE) begin
      ri_d = ri_q + RI_W'(1);
    end
  end

  logic [7:0]       viol;
  logic             any_viol;
  logic [7:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             pulse_q;
  logic             init_done_q;

  assign viol[0]  = init_err;
  assign viol[1]  = run & is_act & open_sel;
  assign viol[2]  = run & is_rw & ~open_sel;
  assign viol[3]  = run & is_rw & rcd_sel;
  assign viol[4]  = run & is_act & rp_sel;
  assign viol[5]  = cmd_live & rfc_busy;
  assign viol[6]  = run & is_ref & (|open_q);
  assign viol[7]  = run & ~is_ref & (ri_q == RI_LAST);
  assign any_viol = |viol;

  assign err_d    = (clear_i ? 8'h00 : err_q) | viol;
  assign cnt_base = clear_i ? '0 : cnt_q;
  assign cnt_d    = (any_viol && cnt_base != {CNT_W{1'b1}}) ? cnt_base + CNT_W'(1) : cnt_base;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      open_q      <= '0;
      rfc_q       <= '0;
      ri_q        <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
      init_done_q <= 1'b0;
      for (int b = 0; b < SDRAM_BANKS; b++) begin
        rcd_q[b] <= '0;
        rp_q[b]  <= '0;
      end
    end else begin
      open_q      <= open_d;
      rfc_q       <= rfc_d;
      ri_q        <= ri_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      pulse_q     <= any_viol;
      init_done_q <= (state_d == ST_RUN);
      for (int b = 0; b < SDRAM_BANKS; b++) begin
        rcd_q[b] <= rcd_d[b];
        rp_q[b]  <= rp_d[b];
      end
    end
  end

  assign err_o       = err_q;
  assign err_pulse_o = pulse_q;
  assign err_count_o = cnt_q;
  assign init_done_o = init_done_q;
  assign bank_open_o = open_q;

endmodule

// File: tb/tb_sdram_timing_monitor.sv
// Scoreboard bench for sdram_timing_monitor: expected outputs are queued per cycle
// as commands are driven and compared one cycle after the sampling edge.
module tb_sdram_timing_monitor;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1;
  logic        cs = 1'b0, ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic [1:0]  ba = '0;
  logic [12:0] addr = '0;
  logic        clear = 1'b0;
  logic [7:0]  err;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        init_done;
  logic [3:0]  bank_open;

  always #5 clk = ~clk;

  sdram_timing_monitor dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sdram_cke_i  (cke),
    .sdram_cs_i   (cs),
    .sdram_ras_i  (ras),
    .sdram_cas_i  (cas),
    .sdram_we_i   (we),
    .sdram_ba_i   (ba),
    .sdram_addr_i (addr),
    .clear_i      (clear),
    .err_o        (err),
    .err_pulse_o  (err_pulse),
    .err_count_o  (err_count),
    .init_done_o  (init_done),
    .bank_open_o  (bank_open)
  );

  typedef struct {
    int          cyc;
    string       tag;
    logic [7:0]  err;
    logic        pulse;
    logic [15:0] cnt;
    logic        init;
    logic [3:0]  open;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] e_err, input logic e_pulse,
                          input logic [15:0] e_cnt, input logic e_init, input logic [3:0] e_open);
    exp_t e;
    e.cyc   = cyc + 1;
    e.tag   = tag;
    e.err   = e_err;
    e.pulse = e_pulse;
    e.cnt   = e_cnt;
    e.init  = e_init;
    e.open  = e_open;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                      input logic clr);
    exp_t e;
    {cs, ras, cas, we} = c;
    ba    = b;
    addr  = a;
    clear = clr;
    @(posedge clk);
    #1;
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check_eq({e.tag, ".err"},   32'(err),       32'(e.err));
      check_eq({e.tag, ".pulse"}, 32'(err_pulse), 32'(e.pulse));
      check_eq({e.tag, ".count"}, 32'(err_count), 32'(e.cnt));
      check_eq({e.tag, ".init"},  32'(init_done), 32'(e.init));
      check_eq({e.tag, ".open"},  32'(bank_open), 32'(e.open));
      $display("[TB] cyc %0d %s err=%02h pulse=%0b cnt=%0d init=%0b open=%04b",
               cyc, e.tag, err, err_pulse, err_count, init_done, bank_open);
    end
    {cs, ras, cas, we} = NOP;
    clear = 1'b0;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(NOP, 2'd0, 13'h0, 1'b0);
  endtask

  initial begin
    // Reset, with a command presented that must be ignored
    push_exp("rst_a", 8'h00, 0, 0, 0, 4'b0000); step(PRE, 0, 13'h400, 0);
    push_exp("rst_b", 8'h00, 0, 0, 0, 4'b0000); step(NOP, 0, 13'h0, 0);
    rst = 1'b0;

    // REF before PRE: init error, FSM holds so the later PRE is legal
    push_exp("init_ref_first", 8'h01, 1, 1, 0, 4'b0000); step(REF, 0, 13'h0, 0);
    nops(7);
    push_exp("init_pre_ok", 8'h01, 0, 1, 0, 4'b0000); step(PRE, 0, 13'h400, 0);
    push_exp("init_clear", 8'h00, 0, 0, 0, 4'b0000); step(NOP, 0, 13'h0, 1);
    step(REF, 0, 13'h0, 0);
    nops(7);
    step(REF, 0, 13'h0, 0);
    nops(7);
    push_exp("init_done", 8'h00, 0, 0, 1, 4'b0000); step(MRS, 0, 13'h0, 0);

    // Refresh interval: cycle 6500 after MODE is fine, cycle 6501 flags once
    nops(6499);
    push_exp("rlate_edge", 8'h00, 0, 0, 1, 4'b0000); step(NOP, 0, 13'h0, 0);
    push_exp("rlate_set", 8'h80, 1, 1, 1, 4'b0000); step(NOP, 0, 13'h0, 0);
    push_exp("rlate_pulse_drop", 8'h80, 0, 1, 1, 4'b0000); step(NOP, 0, 13'h0, 0);
    nops(20);
    push_exp("rlate_once", 8'h80, 0, 1, 1, 4'b0000); step(NOP, 0, 13'h0, 0);
    push_exp("rlate_ref", 8'h80, 0, 1, 1, 4'b0000); step(REF, 0, 13'h0, 0);
    nops(7);
    push_exp("rlate_clear", 8'h00, 0, 0, 1, 4'b0000); step(NOP, 0, 13'h0, 1);

    // tRCD exactly met on bank 1
    push_exp("act_b1", 8'h00, 0, 0, 1, 4'b0010); step(ACT, 1, 13'h0, 0);
    nops(2);
    push_exp("rd_b1_trcd_ok", 8'h00, 0, 0, 1, 4'b0010); step(RD, 1, 13'h0, 0);

    // tRCD one cycle short on bank 2
    push_exp("act_b2", 8'h00, 0, 0, 1, 4'b0110); step(ACT, 2, 13'h0, 0);
    step(NOP, 0, 13'h0, 0);
    push_exp("wr_b2_trcd", 8'h08, 1, 1, 1, 4'b0110); step(WR, 2, 13'h0, 0);
    push_exp("trcd_pulse_drop", 8'h08, 0, 1, 1, 4'b0110); step(NOP, 0, 13'h0, 0);
    push_exp("pre_all_1", 8'h08, 0, 1, 1, 4'b0000); step(PRE, 0, 13'h400, 0);
    push_exp("clear_2", 8'h00, 0, 0, 1, 4'b0000); step(NOP, 0, 13'h0, 1);
    step(NOP, 0, 13'h0, 0);
    push_exp("act_b0_trp_ok", 8'h00, 0, 0, 1, 4'b0001); step(ACT, 0, 13'h0, 0);

    // REFRESH with b0 open, then ACT b0 inside tRFC
    push_exp("ref_open", 8'h40, 1, 1, 1, 4'b0001); step(REF, 0, 13'h0, 0);
    step(NOP, 0, 13'h0, 0);
    push_exp("trfc_act_open", 8'h62, 1, 2, 1, 4'b0001); step(ACT, 0, 13'h0, 0);
    nops(4);
    push_exp("act_b3_trfc_ok", 8'h62, 0, 2, 1, 4'b1001); step(ACT, 3, 13'h0, 0);

    // Precharge-all then ACT b3 two cycles later, with clear in the same cycle
    push_exp("pre_all_2", 8'h62, 0, 2, 1, 4'b0000); step(PRE, 0, 13'h400, 0);
    step(NOP, 0, 13'h0, 0);
    push_exp("trp_with_clear", 8'h10, 1, 1, 1, 4'b1000); step(ACT, 3, 13'h0, 1);

    // READ to a closed bank
    nops(2);
    push_exp("rd_closed", 8'h14, 1, 2, 1, 4'b1000); step(RD, 0, 13'h0, 0);

    // Reset mid-operation discards everything, ignoring the command in that cycle
    rst = 1'b1;
    push_exp("mid_rst", 8'h00, 0, 0, 0, 4'b0000); step(ACT, 1, 13'h0, 0);
    rst = 1'b0;
    push_exp("post_rst", 8'h00, 0, 0, 0, 4'b0000); step(NOP, 0, 13'h0, 0);

    check_eq("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
